// File: rtl/seg_display_pkg.sv
// Shared font table and helpers for the multiplexed 7-segment scanner.
package seg_display_pkg;

    // Active-high segment patterns, bit order g..a, indexed by hex value.
    localparam logic [15:0][6:0] SEG_FONT = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [15:0] apply_pol(input logic active_low, input logic [15:0] v);
        return active_low ? ~v : v;
    endfunction

endpackage

// File: rtl/seg_display_scanner_hex_to_seg.sv
// Combinational hex nibble to active-high 7-segment pattern.
module hex_to_seg
    import seg_display_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_FONT[nibble_i];

endmodule

// File: rtl/seg_display_scanner.sv
// Time-multiplexed common-anode 7-segment driver with frame shadowing,
// inter-digit blanking and PWM brightness; all pin outputs registered.
module seg_display_scanner
    import seg_display_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 8,
    parameter int unsigned REFRESH_DIV    = 100000,
    parameter int unsigned BLANK_CYCLES   = 16,
    parameter int unsigned DIM_BITS       = 4,
    parameter bit          AN_ACTIVE_LOW  = 1'b1,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic [DIM_BITS-1:0]     brightness,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_tick
);

    localparam int unsigned IDX_W = idx_width(NUM_DIGITS);
    localparam int unsigned DIV_W = idx_width(REFRESH_DIV);

    localparam logic [DIV_W-1:0]      DIV_LAST  = DIV_W'(REFRESH_DIV - 1);
    localparam logic [DIV_W-1:0]      BLANK_END = DIV_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_OFF    = NUM_DIGITS'(apply_pol(AN_ACTIVE_LOW, 16'h0000));
    localparam logic [6:0]            SEG_OFF   = 7'(apply_pol(SEG_ACTIVE_LOW, 16'h0000));

    logic [DIV_W-1:0]              div_q,    div_d;
    logic [IDX_W-1:0]              idx_q,    idx_d;
    logic [DIM_BITS-1:0]           pwm_q,    pwm_d;
    logic [NUM_DIGITS-1:0][3:0]    digit_sh_q, digit_sh_d;
    logic [NUM_DIGITS-1:0]         dp_sh_q,  dp_sh_d;
    logic [NUM_DIGITS-1:0]         en_sh_q,  en_sh_d;
    logic [DIM_BITS-1:0]           bright_sh_q, bright_sh_d;
    logic [NUM_DIGITS-1:0]         an_q,     an_d;
    logic [6:0]                    seg_q,    seg_d;
    logic                          dp_q,     dp_d;
    logic                          tick_q,   tick_d;

    logic                          frame_start;
    logic                          blank;
    logic                          lit;
    logic [NUM_DIGITS-1:0]         an_hi;
    logic [6:0]                    seg_raw;

    hex_to_seg u_font (
        .nibble_i (digit_sh_q[idx_q]),
        .seg_o    (seg_raw)
    );

    always_comb begin
        frame_start = (div_q == '0) && (idx_q == '0);

        div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        idx_d = idx_q;
        if (div_q == DIV_LAST) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        pwm_d = pwm_q + 1'b1;

        digit_sh_d  = digit_sh_q;
        dp_sh_d     = dp_sh_q;
        en_sh_d     = en_sh_q;
        bright_sh_d = bright_sh_q;
        if (frame_start) begin
            digit_sh_d  = digits;
            dp_sh_d     = dp_in;
            en_sh_d     = digit_en;
            bright_sh_d = brightness;
        end

        // Outputs use pre-edge counters and shadow, so a shadow load lands in a blank window.
        blank = (div_q < BLANK_END);
        lit   = !blank && en_sh_q[idx_q] &&
                ((bright_sh_q == '1) || (pwm_q < bright_sh_q));

        // Scan index 0 is the leftmost digit, driven on the MSB anode.
        an_hi = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (lit && (idx_q == IDX_W'(NUM_DIGITS - 1 - i))) begin
                an_hi[i] = 1'b1;
            end
        end

        an_d   = NUM_DIGITS'(apply_pol(AN_ACTIVE_LOW, 16'(an_hi)));
        seg_d  = 7'(apply_pol(SEG_ACTIVE_LOW, 16'(seg_raw)));
        dp_d   = dp_sh_q[idx_q] ^ SEG_ACTIVE_LOW;
        tick_d = frame_start;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q       <= '0;
            idx_q       <= '0;
            pwm_q       <= '0;
            digit_sh_q  <= '0;
            dp_sh_q     <= '0;
            en_sh_q     <= '0;
            bright_sh_q <= '0;
            an_q        <= AN_OFF;
            seg_q       <= SEG_OFF;
            dp_q        <= SEG_ACTIVE_LOW;
            tick_q      <= 1'b0;
        end else begin
            div_q       <= div_d;
            idx_q       <= idx_d;
            pwm_q       <= pwm_d;
            digit_sh_q  <= digit_sh_d;
            dp_sh_q     <= dp_sh_d;
            en_sh_q     <= en_sh_d;
            bright_sh_q <= bright_sh_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            tick_q      <= tick_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg_display_scanner.sv
// Directed bench for seg_display_scanner: 4 digits, 8-cycle slots, 2 blank cycles, 2-bit PWM, active-low.
module tb_seg_display_scanner;

    logic        clk;
    logic        reset;
    logic [15:0] digits;
    logic [3:0]  dp_in;
    logic [3:0]  digit_en;
    logic [1:0]  brightness;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;

    int pass_cnt;
    int total_cnt;
    int k;

    // Inverted font, hand-computed from the active-high table.
    logic [6:0] font_inv [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    seg_display_scanner #(
        .NUM_DIGITS     (4),
        .REFRESH_DIV    (8),
        .BLANK_CYCLES   (2),
        .DIM_BITS       (2),
        .AN_ACTIVE_LOW  (1'b1),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .digits     (digits),
        .dp_in      (dp_in),
        .digit_en   (digit_en),
        .brightness (brightness),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s (edge %0d): observed=%h expected=%h", tag, k, obs, exp);
    endtask

    // Advance one clock edge; edge k is counted from the first edge after reset release.
    task automatic step();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic step_to(input int target);
        while (k < target) step();
    endtask

    initial begin
        pass_cnt   = 0;
        total_cnt  = 0;
        k          = -100;
        reset      = 1'b1;
        digits     = 16'h4321;
        dp_in      = 4'b0000;
        digit_en   = 4'hF;
        brightness = 2'b11;

        step();
        step();
        chk("reset_an",   16'(an), 16'h000F);
        chk("reset_seg",  16'(seg), 16'h007F);
        chk("reset_dp",   16'(dp), 16'h0001);
        chk("reset_tick", 16'(frame_tick), 16'h0000);

        reset = 1'b0;
        k = -1;

        // First frame
        step_to(0);
        chk("f0_tick", 16'(frame_tick), 16'h0001);
        chk("f0_an_blank0", 16'(an), 16'h000F);
        step_to(1);
        chk("f0_tick_off", 16'(frame_tick), 16'h0000);
        chk("f0_an_blank1", 16'(an), 16'h000F);
        chk("f0_seg1", 16'(seg), 16'h0079);
        step_to(2);
        chk("d0_an", 16'(an), 16'h0007);
        chk("d0_seg", 16'(seg), 16'h0079);
        chk("d0_dp", 16'(dp), 16'h0001);
        step_to(7);
        chk("d0_an_last", 16'(an), 16'h0007);
        step_to(8);
        chk("d1_an_blank", 16'(an), 16'h000F);
        chk("d1_seg_blank", 16'(seg), 16'h0024);
        step_to(10);
        chk("d1_an", 16'(an), 16'h000B);
        chk("d1_seg", 16'(seg), 16'h0024);
        step_to(18);
        chk("d2_an", 16'(an), 16'h000D);
        chk("d2_seg", 16'(seg), 16'h0030);
        step_to(26);
        chk("d3_an", 16'(an), 16'h000E);
        chk("d3_seg", 16'(seg), 16'h0019);
        step_to(31);
        chk("f0_end_tick", 16'(frame_tick), 16'h0000);
        step_to(32);
        chk("f1_tick", 16'(frame_tick), 16'h0001);
        chk("f1_an_blank", 16'(an), 16'h000F);

        // Shadowing: mid-frame change is invisible until next frame start
        step_to(33);
        digits = 16'hFFFF;
        step_to(34);
        chk("sh_d0_seg", 16'(seg), 16'h0079);
        chk("sh_d0_an", 16'(an), 16'h0007);
        step_to(42);
        chk("sh_d1_seg", 16'(seg), 16'h0024);
        step_to(58);
        chk("sh_d3_seg", 16'(seg), 16'h0019);
        step_to(64);
        chk("sh_tick", 16'(frame_tick), 16'h0001);
        step_to(66);
        chk("sh_new_d0_seg", 16'(seg), 16'h000E);
        chk("sh_new_d0_an", 16'(an), 16'h0007);
        step_to(74);
        chk("sh_new_d1_seg", 16'(seg), 16'h000E);
        chk("sh_new_d1_an", 16'(an), 16'h000B);

        // Enable mask and decimal points (load at edge 96)
        digit_en = 4'b0101;
        dp_in    = 4'b0001;
        step_to(90);
        chk("en_pre_load_d3", 16'(an), 16'h000E);
        step_to(97);
        chk("dp_d0_blank", 16'(dp), 16'h0000);
        step_to(98);
        chk("en_d0_an", 16'(an), 16'h0007);
        chk("dp_d0", 16'(dp), 16'h0000);
        step_to(103);
        chk("dp_d0_last", 16'(dp), 16'h0000);
        step_to(106);
        chk("en_d1_an", 16'(an), 16'h000F);
        chk("dp_d1", 16'(dp), 16'h0001);
        step_to(114);
        chk("en_d2_an", 16'(an), 16'h000D);
        chk("dp_d2", 16'(dp), 16'h0001);
        step_to(122);
        chk("en_d3_an", 16'(an), 16'h000F);

        // Brightness 01: lit only when pwm_cnt==0 (edge index multiple of 4)
        digit_en   = 4'hF;
        dp_in      = 4'b0000;
        brightness = 2'b01;
        step_to(131);
        chk("pwm_d0_off131", 16'(an), 16'h000F);
        step_to(132);
        chk("pwm_d0_on132", 16'(an), 16'h0007);
        step_to(133);
        chk("pwm_d0_off133", 16'(an), 16'h000F);
        step_to(140);
        chk("pwm_d1_on140", 16'(an), 16'h000B);
        step_to(141);
        chk("pwm_d1_off141", 16'(an), 16'h000F);

        // Brightness 0: dark for the whole frame loaded at edge 160
        brightness = 2'b00;
        step_to(159);
        for (int e = 160; e < 192; e++) begin
            step_to(e);
            chk("dark_an", 16'(an), 16'h000F);
        end

        // Font sweep on digit 0, one value per frame starting at edge 192
        brightness = 2'b11;
        for (int v = 0; v < 16; v++) begin
            step_to(191 + 32 * v);
            digits = {12'h000, 4'(v)};
            step_to(194 + 32 * v);
            chk("font_seg", 16'(seg), 16'(font_inv[v]));
            chk("font_an", 16'(an), 16'h0007);
        end

        // Async reset while digit 2 is lit (edge 691 of frame starting at 672)
        step_to(691);
        chk("pre_rst_an", 16'(an), 16'h000D);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_an", 16'(an), 16'h000F);
        chk("arst_seg", 16'(seg), 16'h007F);
        chk("arst_dp", 16'(dp), 16'h0001);
        chk("arst_div", 16'(dut.div_q), 16'h0000);
        chk("arst_idx", 16'(dut.idx_q), 16'h0000);
        chk("arst_pwm", 16'(dut.pwm_q), 16'h0000);
        step();
        step();
        chk("arst_hold_an", 16'(an), 16'h000F);
        reset = 1'b0;
        k = -1;
        step_to(0);
        chk("rst2_tick", 16'(frame_tick), 16'h0001);
        step_to(1);
        chk("rst2_seg", 16'(seg), 16'h000E);
        step_to(2);
        chk("rst2_d0_an", 16'(an), 16'h0007);
        step_to(10);
        chk("rst2_d1_an", 16'(an), 16'h000B);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
